red_pitaya_sort_pulse_gen: RTL and testbench
============================================

Name: red_pitaya_sort_pulse_gen

Overview:
- Consumer end of the FADS sort trigger. Detects rising edges of the sorting trigger and waits a programmable droplet travel delay.
- Then drives a gated, bipolar square-wave burst onto a 14-bit DAC data path that feeds the external high-voltage amplifier.
- Enforces a hold-off window after each burst and keeps saturating counters of sorted and missed (overlapping) triggers for readout by the system-bus register block.

Parameters:
- DW, 14, DAC data width (two's complement output).
- CW, 32, width of the delay, width and hold-off timers and of the event counters.
- HW, 16, width of the carrier half-period setting.

Ports:
- adc_clk_i  in  1  ADC clock; the only clock.
- adc_rstn_i  in  1  asynchronous active-low reset.
- sort_trig_i  in  1  sort request level from the fluorescence detector.
- enable_i  in  1  block enable.
- clr_cnt_i  in  1  synchronous clear of both counters.
- delay_i  in  CW  cycles from trigger edge to burst start.
- width_i  in  CW  burst length in cycles; 0 is treated as 1.
- holdoff_i  in  CW  dead cycles after the burst.
- half_period_i  in  HW  carrier half period in cycles; 0 gives a DC pulse.
- amplitude_i  in  DW-1  unsigned burst magnitude A, range 0..8191.
- dac_o  out  DW  signed DAC sample.
- busy_o  out  1  high whenever the state is not IDLE.
- sort_count_o  out  CW  bursts started.
- missed_count_o  out  CW  trigger edges rejected while busy.

Behaviour:
- Reset (async, adc_rstn_i=0) sets: state=IDLE, dac_o=0, busy_o=0, both counters=0, trigger history register=0.
  - A trigger that is high at reset release therefore counts as an edge on the first clock.
- Edge detect: edge = sort_trig_i & ~trig_q, where trig_q is the registered previous value.
- FSM states: IDLE -> DELAY -> PULSE -> HOLDOFF -> IDLE.
- IDLE:
  - dac_o=0.
  - On edge with enable_i=1 at clock k: latch delay, width, holdoff, half period and A; go to DELAY.
  - Edges with enable_i=0 are ignored and not counted.
- DELAY: counts latched delay cycles.
  - First nonzero dac_o appears at clock k+delay+1; delay=0 gives k+1.
  - sort_count_o increments by 1 on the DELAY->PULSE transition.
- PULSE: lasts exactly max(width,1) cycles.
  - Output is +A for half_period cycles, then -A for half_period cycles, repeating.
  - The phase restarts at +A on every burst.
  - half_period=0 gives +A for the whole pulse.
  - The burst is truncated at width mid-half-cycle if needed.
- HOLDOFF: dac_o=0 for holdoff cycles (0 means straight to IDLE on the next clock), then IDLE.
  - A new edge is accepted in the cycle after entering IDLE.
- Overlap: an edge while state≠IDLE with enable_i=1 increments missed_count_o. It is not queued.
- Config inputs change only the next accepted trigger. Latched values are immune to mid-operation writes.
- enable_i deasserted in any state: next clock goes to IDLE with dac_o=0. The burst is aborted; counters are kept.
- Counters saturate at 2^CW-1.
  - clr_cnt_i wins over a simultaneous increment (result 0).
  - Clearing does not disturb the FSM.
- Output rules:
  - dac_o is registered.
  - -A is formed as the two's complement of zero-extended A and never overflows.
  - busy_o is registered and is 1 exactly in DELAY, PULSE and HOLDOFF.

Test Plan:
- Basic DC pulse. Reset; enable=1, delay=10, width=5, holdoff=3, hp=0, A=1000; single 1-cycle trigger at clock k.
  - Required: dac_o=1000 at k+11..k+15, 0 otherwise.
  - Required: sort_count=1, busy_o low again at k+19, missed=0.
- Carrier. delay=0, width=7, hp=2, A=8191.
  - Required: dac_o sequence +8191,+8191,-8191,-8191,+8191,+8191,-8191, then 0.
- Overlap rejection. delay=20; second edge at k+5, third edge during HOLDOFF.
  - Required: only one burst, sort_count=1, missed_count=2.
  - Required: a fourth edge after busy_o falls produces a second burst.
- Abort and config immunity.
  - Change width_i to 100 during DELAY: the burst still uses the latched 5 cycles.
  - Drop enable_i mid-PULSE: dac_o=0 next clock and state IDLE.
  - Re-enable with a held-high trigger: no burst until a new rising edge.
- Counters. Force sort_count to 2^32-1, then trigger: it stays 2^32-1. clr_cnt_i coincident with the DELAY->PULSE transition: count=0.
- Async reset mid-PULSE: dac_o=0 and busy_o=0 immediately, without waiting for a clock edge. Counters read 0 after release.

Source files
------------

// File: rtl/red_pitaya_sort_pulse_gen.sv
// red_pitaya_sort_pulse_gen: trigger-delayed bipolar burst generator for the FADS sort amplifier
//   adc_clk_i/adc_rstn_i : clock, async active-low reset
//   sort_trig_i          : sort request level (rising edge starts a sequence)
//   enable_i, clr_cnt_i  : block enable, sync counter clear
//   delay_i/width_i/holdoff_i/half_period_i/amplitude_i : burst config, latched on accepted edge
//   dac_o, busy_o        : registered DAC sample and busy flag
//   sort_count_o/missed_count_o : saturating bursts-started / rejected-edge counters
module red_pitaya_sort_pulse_gen #(
  parameter int DW = 14,
  parameter int CW = 32,
  parameter int HW = 16
) (
  input  logic          adc_clk_i,
  input  logic          adc_rstn_i,
  input  logic          sort_trig_i,
  input  logic          enable_i,
  input  logic          clr_cnt_i,
  input  logic [CW-1:0] delay_i,
  input  logic [CW-1:0] width_i,
  input  logic [CW-1:0] holdoff_i,
  input  logic [HW-1:0] half_period_i,
  input  logic [DW-2:0] amplitude_i,
  output logic [DW-1:0] dac_o,
  output logic          busy_o,
  output logic [CW-1:0] sort_count_o,
  output logic [CW-1:0] missed_count_o
);
  typedef enum logic [1:0] {IDLE, DELAY, PULSE, HOLDOFF} state_t;
  state_t        state, state_nxt;
  logic          trig_q, trig_edge, load, start, flip, neg, neg_nxt;
  logic [CW-1:0] cnt, cnt_nxt, dly, wid, hold, w_eff;
  logic [HW-1:0] hp, ph_cnt, ph_nxt;
  logic [DW-2:0] amp;
  logic [DW-1:0] pos_val, neg_val, dac_nxt;
  assign trig_edge = sort_trig_i & ~trig_q;
  assign w_eff     = (wid == '0) ? CW'(1) : wid;
  // flip marks the sample that starts a new half period of the carrier
  assign flip      = (hp != '0) && (ph_cnt == hp);
  assign pos_val   = {1'b0, amp};
  assign neg_val   = '0 - pos_val;
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    ph_nxt    = ph_cnt;
    neg_nxt   = neg;
    dac_nxt   = '0;
    load      = 1'b0;
    start     = 1'b0;
    if (!enable_i) state_nxt = IDLE;
    else begin
      case (state)
        IDLE: if (trig_edge) begin
          state_nxt = DELAY;
          cnt_nxt   = '0;
          load      = 1'b1;
        end
        DELAY: if (cnt == dly) begin
          state_nxt = PULSE;
          cnt_nxt   = CW'(1);
          ph_nxt    = HW'(1);
          neg_nxt   = 1'b0;
          dac_nxt   = pos_val;
          start     = 1'b1;
        end
        PULSE: if (cnt >= w_eff) begin
          state_nxt = (hold == '0) ? IDLE : HOLDOFF;
          cnt_nxt   = CW'(1);
        end else begin
          ph_nxt  = flip ? HW'(1) : ph_cnt + HW'(1);
          neg_nxt = flip ? ~neg : neg;
          dac_nxt = (flip ^ neg) ? neg_val : pos_val;
        end
        HOLDOFF: if (cnt >= hold) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state          <= IDLE;
      trig_q         <= 1'b0;
      cnt            <= '0;
      ph_cnt         <= '0;
      neg            <= 1'b0;
      dly            <= '0;
      wid            <= '0;
      hold           <= '0;
      hp             <= '0;
      amp            <= '0;
      dac_o          <= '0;
      busy_o         <= 1'b0;
      sort_count_o   <= '0;
      missed_count_o <= '0;
    end else begin
      trig_q <= sort_trig_i;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ph_cnt <= ph_nxt;
      neg    <= neg_nxt;
      dac_o  <= dac_nxt;
      busy_o <= (state_nxt != IDLE);
      if (load) begin
        dly  <= delay_i;
        wid  <= width_i;
        hold <= holdoff_i;
        hp   <= half_period_i;
        amp  <= amplitude_i;
      end
      if (clr_cnt_i) sort_count_o <= '0;
      else if (start && sort_count_o != '1) sort_count_o <= sort_count_o + CW'(1);
      if (clr_cnt_i) missed_count_o <= '0;
      else if (enable_i && trig_edge && state != IDLE && missed_count_o != '1)
        missed_count_o <= missed_count_o + CW'(1);
    end
  end
endmodule

// File: tb/tb_red_pitaya_sort_pulse_gen.sv
// tb_red_pitaya_sort_pulse_gen: directed scoreboard bench for the sort pulse generator
module tb_red_pitaya_sort_pulse_gen;
  logic        clk = 1'b0, rst_n = 1'b0, trig = 1'b0, en = 1'b0, clr = 1'b0, trig2 = 1'b0;
  logic [31:0] dly = '0, wid = '0, hold = '0;
  logic [15:0] hp = '0;
  logic [12:0] amp = '0;
  logic [13:0] dac, dac2;
  logic        busy, busy2;
  logic [31:0] sort_c, miss_c;
  logic [3:0]  sort2, miss2;
  int          checks = 0, errors = 0;
  logic [14:0] expq[$];
  always #5 clk = ~clk;
  red_pitaya_sort_pulse_gen dut (
    .adc_clk_i(clk), .adc_rstn_i(rst_n), .sort_trig_i(trig), .enable_i(en), .clr_cnt_i(clr),
    .delay_i(dly), .width_i(wid), .holdoff_i(hold), .half_period_i(hp), .amplitude_i(amp),
    .dac_o(dac), .busy_o(busy), .sort_count_o(sort_c), .missed_count_o(miss_c)
  );
  red_pitaya_sort_pulse_gen #(.CW(4)) dut_small (
    .adc_clk_i(clk), .adc_rstn_i(rst_n), .sort_trig_i(trig2), .enable_i(en), .clr_cnt_i(1'b0),
    .delay_i(4'd0), .width_i(4'd1), .holdoff_i(4'd0), .half_period_i(16'd0), .amplitude_i(13'd1),
    .dac_o(dac2), .busy_o(busy2), .sort_count_o(sort2), .missed_count_o(miss2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fire();
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask
  task automatic cfg(input int d, input int w, input int h, input int p, input int a);
    dly = d; wid = w; hold = h; hp = 16'(p); amp = 13'(a);
  endtask
  // expected {busy, dac} for clocks k+1..k+n after a trigger accepted at clock k
  task automatic push_burst(input int d, input int w, input int h, input int p, input int a, input int n);
    int weff, j;
    logic [13:0] v;
    weff = (w == 0) ? 1 : w;
    for (int i = 1; i <= n; i++) begin
      j = i - d - 1;
      v = '0;
      if (j >= 0 && j < weff) begin
        v = 14'(a);
        if (p != 0 && ((j / p) % 2) == 1) v = 14'd0 - v;
      end
      expq.push_back({(i <= d + weff + h) ? 1'b1 : 1'b0, v});
    end
  endtask
  task automatic drain(input int ta, input int tb, input int en_off, input int clr_at);
    int i;
    logic [14:0] e;
    i = 0;
    while (expq.size() > 0) begin
      i++;
      trig = (i == ta || i == tb);
      clr  = (i == clr_at);
      if (i == en_off) en = 1'b0;
      step();
      e = expq.pop_front();
      chk("dac", 32'(dac), 32'(e[13:0]));
      chk("busy", 32'(busy), 32'(e[14]));
    end
    trig = 1'b0;
    clr  = 1'b0;
  endtask
  initial begin
    step();
    step();
    chk("rst_dac", 32'(dac), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sort", sort_c, 0);
    chk("rst_miss", miss_c, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    cfg(10, 5, 3, 0, 1000);
    step();
    fire();
    push_burst(10, 5, 3, 0, 1000, 20);
    drain(0, 0, 0, 0);
    chk("dc_sort", sort_c, 1);
    chk("dc_miss", miss_c, 0);
    cfg(0, 7, 2, 2, 8191);
    fire();
    push_burst(0, 7, 2, 2, 8191, 12);
    drain(0, 0, 0, 0);
    chk("car_sort", sort_c, 2);
    cfg(20, 5, 3, 0, 500);
    fire();
    push_burst(20, 5, 3, 0, 500, 30);
    drain(5, 27, 0, 0);
    chk("ovl_sort", sort_c, 3);
    chk("ovl_miss", miss_c, 2);
    fire();
    push_burst(20, 5, 3, 0, 500, 30);
    drain(0, 0, 0, 0);
    chk("ovl_sort2", sort_c, 4);
    cfg(5, 5, 2, 0, 300);
    fire();
    wid = 100;
    push_burst(5, 5, 2, 0, 300, 15);
    drain(0, 0, 0, 0);
    chk("imm_sort", sort_c, 5);
    cfg(3, 10, 2, 0, 700);
    fire();
    for (int i = 1; i <= 10; i++) expq.push_back({(i <= 6) ? 1'b1 : 1'b0, (i >= 4 && i <= 6) ? 14'd700 : 14'd0});
    drain(0, 0, 7, 0);
    chk("abort_sort", sort_c, 6);
    trig = 1'b1;
    step();
    step();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("held_dac", 32'(dac), 0);
      chk("held_busy", 32'(busy), 0);
    end
    trig = 1'b0;
    step();
    fire();
    push_burst(3, 10, 2, 0, 700, 18);
    drain(0, 0, 0, 0);
    chk("reen_sort", sort_c, 7);
    chk("reen_miss", miss_c, 2);
    cfg(2, 4, 1, 0, 50);
    fire();
    push_burst(2, 4, 1, 0, 50, 8);
    drain(0, 0, 0, 3);
    chk("clr_sort", sort_c, 0);
    chk("clr_miss", miss_c, 0);
    for (int i = 0; i < 17; i++) begin
      trig2 = 1'b1;
      step();
      trig2 = 1'b0;
      step();
      step();
      step();
    end
    chk("sat_sort", 32'(sort2), 15);
    chk("sat_miss", 32'(miss2), 0);
    cfg(1, 10, 2, 0, 1234);
    fire();
    step();
    step();
    step();
    chk("pre_rst_dac", 32'(dac), 1234);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dac", 32'(dac), 0);
    chk("arst_busy", 32'(busy), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_sort", sort_c, 0);
    chk("post_miss", miss_c, 0);
    chk("post_dac", 32'(dac), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
